// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register: valid/ready handshake, synchronous flush, optional
// second (skid) entry and a saturating count of cycles with nothing presented downstream.
//  state    | meaning
//  ST_EMPTY | nothing held; out_ctrl is zero (NOP presented)
//  ST_HALF  | main register holds the entry presented downstream
//  ST_FULL  | main presented, skid holds the next entry, in_ready low (SKID=1 only)
module pipe_skid_reg #(
   parameter int CTRL_W     = 14,
   parameter int DATA_W     = 143,
   parameter int SKID       = 1,
   parameter int CLEAR_DATA = 1,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              clr_stats,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            state;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic              accept;
   logic              emit;

   assign out_valid = (state != ST_EMPTY);
   assign occupancy = state;
   assign accept    = in_valid & in_ready;
   assign emit      = out_valid & out_ready;

   generate
      if (SKID != 0) begin : g_skid
         // Only a decode of the state flop, so upstream sees no combinational path from out_ready.
         assign in_ready = (state != ST_FULL);
      end else begin : g_noskid
         assign in_ready = out_ready | ~out_valid;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_EMPTY;
         out_ctrl  <= '0;
         out_data  <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else if (flush) begin
         state     <= ST_EMPTY;
         out_ctrl  <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
         if (CLEAR_DATA != 0) out_data <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state    <= ST_HALF;
                  out_ctrl <= in_ctrl;
                  out_data <= in_data;
               end
            end
            ST_HALF: begin
               if (accept && emit) begin
                  out_ctrl <= in_ctrl;
                  out_data <= in_data;
               end else if (accept) begin
                  if (SKID != 0) begin
                     state     <= ST_FULL;
                     skid_ctrl <= in_ctrl;
                     skid_data <= in_data;
                  end
               end else if (emit) begin
                  state    <= ST_EMPTY;
                  out_ctrl <= '0;
                  if (CLEAR_DATA != 0) out_data <= '0;
               end
            end
            ST_FULL: begin
               if (emit) begin
                  state     <= ST_HALF;
                  out_ctrl  <= skid_ctrl;
                  out_data  <= skid_data;
                  skid_ctrl <= '0;
                  skid_data <= '0;
               end
            end
            default: begin
               state    <= ST_EMPTY;
               out_ctrl <= '0;
            end
         endcase
      end
   end

   // Counts on the pre-edge out_valid; flush deliberately does not touch the statistic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt <= '0;
      end else if (clr_stats) begin
         bubble_cnt <= '0;
      end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a skid instance (default widths) and a no-skid instance with
// a 4-bit bubble counter, directed scenarios plus randomized traffic against a queue model.
module tb_pipe_skid_reg;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // instance a: SKID=1, CTRL_W=14, DATA_W=143, CNT_W=16
   logic         a_flush = 0, a_clr = 0, a_in_valid = 0, a_out_ready = 0;
   logic         a_in_ready, a_out_valid;
   logic [13:0]  a_in_ctrl = '0, a_out_ctrl;
   logic [142:0] a_in_data = '0, a_out_data;
   logic [1:0]   a_occ;
   logic [15:0]  a_bub;

   // instance b: SKID=0, CTRL_W=8, DATA_W=16, CNT_W=4
   logic         b_flush = 0, b_clr = 0, b_in_valid = 0, b_out_ready = 0;
   logic         b_in_ready, b_out_valid;
   logic [7:0]   b_in_ctrl = '0, b_out_ctrl;
   logic [15:0]  b_in_data = '0, b_out_data;
   logic [1:0]   b_occ;
   logic [3:0]   b_bub;

   typedef struct packed {logic [13:0] c; logic [142:0] d;} ent_a_t;
   typedef struct packed {logic [7:0] c; logic [15:0] d;} ent_b_t;

   pipe_skid_reg #(.CTRL_W(14), .DATA_W(143), .SKID(1), .CLEAR_DATA(1), .CNT_W(16)) u_dut_a (
      .clk(clk), .rst(rst), .flush(a_flush), .clr_stats(a_clr),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
      .occupancy(a_occ), .bubble_cnt(a_bub));

   pipe_skid_reg #(.CTRL_W(8), .DATA_W(16), .SKID(0), .CLEAR_DATA(1), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst(rst), .flush(b_flush), .clr_stats(b_clr),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
      .occupancy(b_occ), .bubble_cnt(b_bub));

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid: got %b exp 0", a_out_valid); end
      checks++; if (a_out_ctrl !== 14'h0) begin errors++; $display("FAIL rst_a_ctrl: got %h exp 0", a_out_ctrl); end
      checks++; if (a_out_data !== 143'h0) begin errors++; $display("FAIL rst_a_data: got %h exp 0", a_out_data); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_a_in_ready: got %b exp 1", a_in_ready); end
      checks++; if (a_bub !== 16'h0) begin errors++; $display("FAIL rst_a_bubble: got %h exp 0", a_bub); end
      checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid: got %b exp 0", b_out_valid); end
      checks++; if (b_bub !== 4'h0) begin errors++; $display("FAIL rst_b_bubble: got %h exp 0", b_bub); end
      rst = 1'b0;
      // fill a to occupancy 2, then reset mid-stream
      a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 14'h11; a_in_data = 143'h1111;
      @(negedge clk); a_in_ctrl = 14'h22; a_in_data = 143'h2222;
      @(negedge clk); a_in_valid = 0;
      checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL rst_fill_occ: got %0d exp 2", a_occ); end
      rst = 1'b1;
      #1;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b exp 0", a_out_valid); end
      checks++; if (a_out_ctrl !== 14'h0) begin errors++; $display("FAIL rst_async_ctrl: got %h exp 0", a_out_ctrl); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_in_ready: got %b exp 1", a_in_ready); end
      checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL rst_async_occ: got %0d exp 0", a_occ); end
      @(negedge clk); rst = 1'b0; a_out_ready = 1;
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_after_valid: got %b exp 0", a_out_valid); end
   endtask

   task automatic test_stream();
      @(negedge clk);
      a_clr = 1; a_out_ready = 1; a_in_valid = 1; a_in_ctrl = 14'd1; a_in_data = 143'd4;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         a_clr = 0;
         checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d: got %b exp 1", k, a_out_valid); end
         checks++; if (a_out_ctrl !== 14'(k)) begin errors++; $display("FAIL stream_ctrl k=%0d: got %0d exp %0d", k, a_out_ctrl, k); end
         checks++; if (a_out_data !== 143'(k * 3 + 1)) begin errors++; $display("FAIL stream_data k=%0d: got %0d exp %0d", k, a_out_data, k * 3 + 1); end
         checks++; if (a_occ !== 2'd1) begin errors++; $display("FAIL stream_occ k=%0d: got %0d exp 1", k, a_occ); end
         checks++; if (a_bub !== 16'd0) begin errors++; $display("FAIL stream_bubble k=%0d: got %0d exp 0", k, a_bub); end
         if (k < 8) begin
            a_in_ctrl = 14'(k + 1); a_in_data = 143'((k + 1) * 3 + 1);
         end else begin
            a_in_valid = 0;
         end
      end
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 14'h0) begin errors++; $display("FAIL stream_drain: got valid %b ctrl %h exp 0 0", a_out_valid, a_out_ctrl); end
      checks++; if (a_bub !== 16'd0) begin errors++; $display("FAIL stream_bub_drain: got %0d exp 0", a_bub); end
      @(negedge clk);
      checks++; if (a_bub !== 16'd1) begin errors++; $display("FAIL stream_bub_idle: got %0d exp 1", a_bub); end
   endtask

   task automatic test_skid_stall();
      a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 14'h0A; a_in_data = 143'hAAA;
      @(negedge clk);
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_half: got %b exp 1", a_in_ready); end
      a_in_ctrl = 14'h0B; a_in_data = 143'hBBB;
      @(negedge clk);
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_full: got %b exp 0", a_in_ready); end
      checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL skid_occ_full: got %0d exp 2", a_occ); end
      a_in_ctrl = 14'h0C; a_in_data = 143'hCCC;
      @(negedge clk);
      checks++; if (a_out_ctrl !== 14'h0A || a_out_data !== 143'hAAA) begin errors++; $display("FAIL skid_hold_a: got %h/%h exp 00a/aaa", a_out_ctrl, a_out_data); end
      checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL skid_hold_flags: got valid %b ready %b exp 1 0", a_out_valid, a_in_ready); end
      a_out_ready = 1;
      @(negedge clk);
      checks++; if (a_out_ctrl !== 14'h0B || a_out_data !== 143'hBBB) begin errors++; $display("FAIL skid_out_b: got %h/%h exp 00b/bbb", a_out_ctrl, a_out_data); end
      checks++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1) begin errors++; $display("FAIL skid_after_b: got occ %0d ready %b exp 1 1", a_occ, a_in_ready); end
      @(negedge clk);
      a_in_valid = 0;
      checks++; if (a_out_ctrl !== 14'h0C || a_out_data !== 143'hCCC) begin errors++; $display("FAIL skid_out_c: got %h/%h exp 00c/ccc", a_out_ctrl, a_out_data); end
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 14'h0) begin errors++; $display("FAIL skid_empty: got valid %b ctrl %h exp 0 0", a_out_valid, a_out_ctrl); end
   endtask

   task automatic test_flush();
      a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 14'h31; a_in_data = 143'h313;
      @(negedge clk); a_in_ctrl = 14'h32; a_in_data = 143'h323;
      @(negedge clk);
      checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d exp 2", a_occ); end
      a_in_ctrl = 14'h33; a_in_data = 143'h333; a_flush = 1;
      @(negedge clk);
      a_flush = 0; a_in_valid = 0; a_out_ready = 1;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", a_out_valid); end
      checks++; if (a_out_ctrl !== 14'h0) begin errors++; $display("FAIL flush_ctrl: got %h exp 0", a_out_ctrl); end
      checks++; if (a_out_data !== 143'h0) begin errors++; $display("FAIL flush_data: got %h exp 0", a_out_data); end
      checks++; if (a_occ !== 2'd0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_occ_ready: got occ %0d ready %b exp 0 1", a_occ, a_in_ready); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_emit k=%0d: got valid %b ctrl %h exp 0", k, a_out_valid, a_out_ctrl); end
      end
   endtask

   task automatic test_bubble_sat();
      b_in_valid = 0; b_out_ready = 1; b_clr = 1;
      @(negedge clk);
      b_clr = 0;
      checks++; if (b_bub !== 4'd0) begin errors++; $display("FAIL bub_clr_start: got %0d exp 0", b_bub); end
      repeat (15) @(negedge clk);
      checks++; if (b_bub !== 4'd15) begin errors++; $display("FAIL bub_reach_max: got %0d exp 15", b_bub); end
      repeat (5) @(negedge clk);
      checks++; if (b_bub !== 4'd15) begin errors++; $display("FAIL bub_saturate: got %0d exp 15", b_bub); end
      b_clr = 1;
      @(negedge clk);
      b_clr = 0;
      checks++; if (b_bub !== 4'd0) begin errors++; $display("FAIL bub_clr: got %0d exp 0", b_bub); end
   endtask

   task automatic test_noskid();
      b_out_ready = 0; b_in_valid = 1; b_in_ctrl = 8'h05; b_in_data = 16'h0505;
      #1;
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL noskid_ready_empty: got %b exp 1", b_in_ready); end
      @(negedge clk);
      b_in_ctrl = 8'h06; b_in_data = 16'h0606;
      #1;
      checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL noskid_ready_stall: got %b exp 0", b_in_ready); end
      @(negedge clk);
      checks++; if (b_out_ctrl !== 8'h05 || b_occ !== 2'd1) begin errors++; $display("FAIL noskid_hold: got ctrl %h occ %0d exp 05 1", b_out_ctrl, b_occ); end
      b_out_ready = 1;
      #1;
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL noskid_ready_go: got %b exp 1", b_in_ready); end
      @(negedge clk);
      b_in_valid = 0;
      checks++; if (b_out_ctrl !== 8'h06 || b_out_data !== 16'h0606 || b_occ !== 2'd1) begin errors++; $display("FAIL noskid_replace: got %h/%h occ %0d exp 06/0606 1", b_out_ctrl, b_out_data, b_occ); end
      @(negedge clk);
      checks++; if (b_out_valid !== 1'b0 || b_out_ctrl !== 8'h0 || b_out_data !== 16'h0) begin errors++; $display("FAIL noskid_drain: got %b %h %h exp 0 0 0", b_out_valid, b_out_ctrl, b_out_data); end
   endtask

   task automatic test_random_skid();
      ent_a_t       q[$];
      ent_a_t       e;
      logic [15:0]  mbub;
      logic [159:0] rnd;
      logic [13:0]  ec;
      logic [142:0] ed;
      logic         acc, emt;
      @(negedge clk);
      a_flush = 1; a_clr = 1; a_in_valid = 0; a_out_ready = 0;
      mbub = 16'd0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         ec = (q.size() > 0) ? q[0].c : 14'h0;
         ed = (q.size() > 0) ? q[0].d : 143'h0;
         checks++; if (a_out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_a_valid cyc %0d: got %b exp %b", i, a_out_valid, q.size() > 0); end
         checks++; if (a_out_ctrl !== ec) begin errors++; $display("FAIL rand_a_ctrl cyc %0d: got %h exp %h", i, a_out_ctrl, ec); end
         checks++; if (a_out_data !== ed) begin errors++; $display("FAIL rand_a_data cyc %0d: got %h exp %h", i, a_out_data, ed); end
         checks++; if (a_occ !== 2'(q.size())) begin errors++; $display("FAIL rand_a_occ cyc %0d: got %0d exp %0d", i, a_occ, q.size()); end
         checks++; if (a_in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rand_a_ready cyc %0d: got %b exp %b", i, a_in_ready, q.size() < 2); end
         checks++; if (a_bub !== mbub) begin errors++; $display("FAIL rand_a_bubble cyc %0d: got %0d exp %0d", i, a_bub, mbub); end
         rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
         a_in_valid  = ($urandom_range(0, 3) != 0);
         a_in_ctrl   = rnd[157:144];
         a_in_data   = rnd[142:0];
         a_out_ready = ($urandom_range(0, 2) != 0);
         a_flush     = ($urandom_range(0, 19) == 0);
         a_clr       = ($urandom_range(0, 29) == 0);
         acc = a_in_valid && (q.size() < 2);
         emt = (q.size() > 0) && a_out_ready;
         if (a_clr) mbub = 16'd0;
         else if (q.size() == 0 && mbub != 16'hFFFF) mbub = mbub + 16'd1;
         if (a_flush) begin
            q.delete();
         end else begin
            if (emt) void'(q.pop_front());
            if (acc) begin e.c = a_in_ctrl; e.d = a_in_data; q.push_back(e); end
         end
      end
      @(negedge clk);
      a_flush = 0; a_clr = 0; a_in_valid = 0;
   endtask

   task automatic test_random_noskid();
      ent_b_t      q[$];
      ent_b_t      e;
      logic [3:0]  mbub;
      logic [7:0]  ec;
      logic [15:0] ed;
      logic        rdy, acc, emt;
      @(negedge clk);
      b_flush = 1; b_clr = 1; b_in_valid = 0; b_out_ready = 0;
      mbub = 4'd0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         ec = (q.size() > 0) ? q[0].c : 8'h0;
         ed = (q.size() > 0) ? q[0].d : 16'h0;
         checks++; if (b_out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_b_valid cyc %0d: got %b exp %b", i, b_out_valid, q.size() > 0); end
         checks++; if (b_out_ctrl !== ec || b_out_data !== ed) begin errors++; $display("FAIL rand_b_out cyc %0d: got %h/%h exp %h/%h", i, b_out_ctrl, b_out_data, ec, ed); end
         checks++; if (b_occ !== 2'(q.size())) begin errors++; $display("FAIL rand_b_occ cyc %0d: got %0d exp %0d", i, b_occ, q.size()); end
         checks++; if (b_bub !== mbub) begin errors++; $display("FAIL rand_b_bubble cyc %0d: got %0d exp %0d", i, b_bub, mbub); end
         b_in_valid  = ($urandom_range(0, 3) != 0);
         b_in_ctrl   = 8'($urandom);
         b_in_data   = 16'($urandom);
         b_out_ready = ($urandom_range(0, 2) != 0);
         b_flush     = ($urandom_range(0, 19) == 0);
         b_clr       = ($urandom_range(0, 29) == 0);
         rdy = b_out_ready || (q.size() == 0);
         #1;
         checks++; if (b_in_ready !== rdy) begin errors++; $display("FAIL rand_b_ready cyc %0d: got %b exp %b", i, b_in_ready, rdy); end
         acc = b_in_valid && rdy;
         emt = (q.size() > 0) && b_out_ready;
         if (b_clr) mbub = 4'd0;
         else if (q.size() == 0 && mbub != 4'hF) mbub = mbub + 4'd1;
         if (b_flush) begin
            q.delete();
         end else begin
            if (emt) void'(q.pop_front());
            if (acc) begin e.c = b_in_ctrl; e.d = b_in_data; q.push_back(e); end
         end
      end
      @(negedge clk);
      b_flush = 0; b_clr = 0; b_in_valid = 0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_skid_stall();
      test_flush();
      test_bubble_sat();
      test_noskid();
      test_random_skid();
      test_random_noskid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
